// File: rtl/gmii_pkt_gen_8b.sv
// rtl/gmii_pkt_gen_8b.sv - paced GMII frame generator (SOP/preamble/SFD/payload/EOP/IPG)
// Optional CRC-32 FCS insertion when PKT_GEN_FCS_EN is defined.
module gmii_pkt_gen_8b #(
  parameter int MIN_IPG      = 12,
  parameter int PREAMBLE_LEN = 6
) (
  input  logic        xaui_clk,
  input  logic        reset,
  input  logic [1:0]  fmac_speed,
  input  logic        start,
  input  logic [10:0] pkt_len,
  input  logic [7:0]  pkt_num,
  input  logic [7:0]  ipg_len,
  input  logic [7:0]  seed,
  output logic [7:0]  data_out,
  output logic        ctrl_out,
  output logic        busy,
  output logic        pkt_done,
  output logic [7:0]  pkt_cnt
);
  typedef enum logic [2:0] {
    S_IDLE, S_SOP, S_PRE, S_SFD, S_PAY, S_FCS, S_EOP, S_IPG
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  speed_q;
  logic [10:0] len_q;
  logic [7:0]  num_q, ipg_q;
  logic [6:0]  pace_q, pace_d, pace_max;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  pay_q, pay_d;
  logic        strobe, launch;
  logic [7:0]  data_q, data_d, pkt_cnt_q, pkt_cnt_d;
  logic        ctrl_q, ctrl_d, busy_q, busy_d, done_q, done_d;

  assign launch = (state_q == S_IDLE) && start;

  always_comb begin
    case (speed_q)
      2'b10:   pace_max = 7'd9;
      2'b11:   pace_max = 7'd99;
      default: pace_max = 7'd0;
    endcase
  end
  assign strobe = (pace_q == pace_max);

`ifdef PKT_GEN_FCS_EN
  logic [31:0] crc_q, crc_d, fcs;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // CRC folds in each payload byte as it leaves the output, so it is complete on FCS entry
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_SOP) crc_d = 32'hFFFF_FFFF;
    else if (state_q == S_PAY && strobe) crc_d = crc_step(crc_q, pay_q);
  end
  assign fcs = ~crc_d;

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) crc_q <= 32'hFFFF_FFFF;
    else       crc_q <= crc_d;
  end

  localparam state_e PAY_NEXT = S_FCS;
`else
  localparam state_e PAY_NEXT = S_EOP;
`endif

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (start) state_d = S_SOP;
    end else if (strobe) begin
      case (state_q)
        S_SOP: state_d = S_PRE;
        S_PRE: if (cnt_q == 11'(PREAMBLE_LEN - 1)) state_d = S_SFD;
        S_SFD: state_d = S_PAY;
        S_PAY: if (cnt_q == len_q - 11'd1) state_d = PAY_NEXT;
        S_FCS: if (cnt_q == 11'd3) state_d = S_EOP;
        S_EOP: state_d = S_IPG;
        S_IPG: if (cnt_q == {3'd0, ipg_q} - 11'd1)
                 state_d = (pkt_cnt_q < num_q) ? S_SOP : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pace_d = (state_q == S_IDLE || strobe) ? 7'd0 : pace_q + 7'd1;
    if (state_q == S_IDLE || state_d != state_q) cnt_d = 11'd0;
    else if (strobe)                             cnt_d = cnt_q + 11'd1;
    else                                         cnt_d = cnt_q;
    pay_d = pay_q;
    if (launch)                        pay_d = seed;
    else if (state_q == S_PAY && strobe) pay_d = pay_q + 8'd1;
  end

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      pace_q  <= 7'd0;
      cnt_q   <= 11'd0;
      pay_q   <= 8'd0;
      speed_q <= 2'd0;
      len_q   <= 11'd1;
      num_q   <= 8'd1;
      ipg_q   <= 8'(MIN_IPG);
    end else begin
      pace_q <= pace_d;
      cnt_q  <= cnt_d;
      pay_q  <= pay_d;
      if (launch) begin
        speed_q <= fmac_speed;
        len_q   <= (pkt_len == 11'd0) ? 11'd1 : pkt_len;
        num_q   <= (pkt_num == 8'd0) ? 8'd1 : pkt_num;
        ipg_q   <= (int'(ipg_len) < MIN_IPG) ? 8'(MIN_IPG) : ipg_len;
      end
    end
  end

  // Outputs decode the upcoming state so the byte lands in a register on the same edge
  always_comb begin
    data_d = 8'h07;
    ctrl_d = 1'b1;
    case (state_d)
      S_SOP: data_d = 8'hFB;
      S_PRE: begin data_d = 8'h55; ctrl_d = 1'b0; end
      S_SFD: begin data_d = 8'hD5; ctrl_d = 1'b0; end
      S_PAY: begin data_d = pay_d; ctrl_d = 1'b0; end
`ifdef PKT_GEN_FCS_EN
      S_FCS: begin data_d = fcs[{cnt_d[1:0], 3'b000} +: 8]; ctrl_d = 1'b0; end
`endif
      S_EOP: data_d = 8'hFD;
      default: ;
    endcase
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_EOP) && (state_q != S_EOP);
    pkt_cnt_d = pkt_cnt_q;
    if (launch)                               pkt_cnt_d = 8'd0;
    else if (done_d && pkt_cnt_q != 8'hFF)    pkt_cnt_d = pkt_cnt_q + 8'd1;
  end

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      data_q    <= 8'h07;
      ctrl_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pkt_cnt_q <= 8'd0;
    end else begin
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign data_out = data_q;
  assign ctrl_out = ctrl_q;
  assign busy     = busy_q;
  assign pkt_done = done_q;
  assign pkt_cnt  = pkt_cnt_q;
endmodule

// File: tb/tb_gmii_pkt_gen_8b.sv
// tb/tb_gmii_pkt_gen_8b.sv - directed and randomized bursts against a frame-list reference model
module tb_gmii_pkt_gen_8b;
  logic        xaui_clk = 1'b0;
  logic        reset;
  logic [1:0]  fmac_speed;
  logic        start;
  logic [10:0] pkt_len;
  logic [7:0]  pkt_num, ipg_len, seed;
  logic [7:0]  data_out;
  logic        ctrl_out, busy, pkt_done;
  logic [7:0]  pkt_cnt;

  int total = 0;
  int fails = 0;
  logic [7:0] exp_b[$];
  logic       exp_c[$];

  gmii_pkt_gen_8b dut (
    .xaui_clk   (xaui_clk),
    .reset      (reset),
    .fmac_speed (fmac_speed),
    .start      (start),
    .pkt_len    (pkt_len),
    .pkt_num    (pkt_num),
    .ipg_len    (ipg_len),
    .seed       (seed),
    .data_out   (data_out),
    .ctrl_out   (ctrl_out),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 xaui_clk = ~xaui_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-serial Ethernet CRC-32 over a byte list, already complemented
  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[k][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic put(input logic [7:0] b, input logic c);
    exp_b.push_back(b);
    exp_c.push_back(c);
  endtask

  task automatic build_model(input logic [10:0] len, input logic [7:0] num,
                             input logic [7:0] ipg, input logic [7:0] sd);
    int le, ne, ge;
    logic [7:0] v;
    logic [7:0] pay[$];
    logic [31:0] crc;
    exp_b.delete();
    exp_c.delete();
    le = (len == 0) ? 1 : int'(len);
    ne = (num == 0) ? 1 : int'(num);
    ge = (ipg < 12) ? 12 : int'(ipg);
    v  = sd;
    for (int p = 0; p < ne; p++) begin
      put(8'hFB, 1'b1);
      for (int k = 0; k < 6; k++) put(8'h55, 1'b0);
      put(8'hD5, 1'b0);
      pay.delete();
      for (int k = 0; k < le; k++) begin
        put(v, 1'b0);
        pay.push_back(v);
        v = v + 8'd1;
      end
`ifdef PKT_GEN_FCS_EN
      crc = ref_crc(pay);
      for (int k = 0; k < 4; k++) put(crc[8*k +: 8], 1'b0);
`else
      crc = 32'd0;
`endif
      put(8'hFD, 1'b1);
      for (int k = 0; k < ge; k++) put(8'h07, 1'b1);
    end
  endtask

  task automatic run_burst(input logic [1:0] spd, input logic [10:0] len, input logic [7:0] num,
                           input logic [7:0] ipg, input logic [7:0] sd, input int restart_at);
    int div, cyc, fd_seen, ne;
    logic is_fd;
    build_model(len, num, ipg, sd);
    div = (spd == 2'b10) ? 10 : (spd == 2'b11) ? 100 : 1;
    ne  = (num == 0) ? 1 : int'(num);
    @(negedge xaui_clk);
    fmac_speed = spd; pkt_len = len; pkt_num = num; ipg_len = ipg; seed = sd; start = 1'b1;
    @(posedge xaui_clk); #1;
    start      = 1'b0;
    fmac_speed = 2'($urandom);
    pkt_len    = 11'($urandom);
    pkt_num    = 8'($urandom);
    ipg_len    = 8'($urandom);
    seed       = 8'($urandom);
    cyc = 1;
    fd_seen = 0;
    for (int i = 0; i < exp_b.size(); i++) begin
      is_fd = exp_c[i] && (exp_b[i] == 8'hFD);
      if (is_fd) fd_seen++;
      for (int h = 0; h < div; h++) begin
        chk("data_out", data_out, exp_b[i]);
        chk("ctrl_out", ctrl_out, exp_c[i]);
        chk("busy", busy, 1);
        chk("pkt_done", pkt_done, is_fd && (h == 0));
        chk("pkt_cnt", pkt_cnt, fd_seen);
        if (cyc == restart_at) start = 1'b1;
        @(posedge xaui_clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    chk("end_busy", busy, 0);
    chk("end_data", data_out, 8'h07);
    chk("end_ctrl", ctrl_out, 1);
    chk("end_done", pkt_done, 0);
    chk("end_cnt", pkt_cnt, ne);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, data_out, 8'h07);
    chk({tag, "_ctrl"}, ctrl_out, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, pkt_done, 0);
    chk({tag, "_cnt"}, pkt_cnt, 0);
  endtask

  initial begin
    reset = 1'b1; fmac_speed = 2'd0; start = 1'b0;
    pkt_len = 11'd0; pkt_num = 8'd0; ipg_len = 8'd0; seed = 8'd0;
    #12;
    chk_reset_vals("por");
    @(negedge xaui_clk);
    reset = 1'b0;

    run_burst(2'b01, 11'd4, 8'd1, 8'd12, 8'h10, -1);
    run_burst(2'b00, 11'd2, 8'd3, 8'd3, 8'hFE, -1);
    run_burst(2'b10, 11'd1, 8'd1, 8'd12, 8'($urandom), -1);
    run_burst(2'b00, 11'd6, 8'd1, 8'd12, 8'($urandom), 5);

    // Reset during the third payload byte of a 64-byte packet
    @(negedge xaui_clk);
    fmac_speed = 2'b00; pkt_len = 11'd64; pkt_num = 8'd1; ipg_len = 8'd12; seed = 8'h40; start = 1'b1;
    @(posedge xaui_clk); #1;
    start = 1'b0;
    repeat (10) @(posedge xaui_clk);
    #2;
    chk("pay_byte3", data_out, 8'h42);
    chk("pay_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge xaui_clk);
    reset = 1'b0;

    run_burst(2'b00, 11'd5, 8'd2, 8'd14, 8'($urandom), -1);
    run_burst(2'b00, 11'd0, 8'd0, 8'd0, 8'($urandom), -1);
    for (int n = 0; n < 4; n++)
      run_burst(2'($urandom_range(0, 2)), 11'($urandom_range(1, 40)), 8'($urandom_range(1, 3)),
                8'($urandom_range(0, 20)), 8'($urandom), -1);
    run_burst(2'b11, 11'd1, 8'd1, 8'd12, 8'($urandom), -1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/gmii_pkt_gen_8b.md
# gmii_pkt_gen_8b

- Upstream 8-bit GMII receive-stimulus source for the PHY emulator.
- Produces framed packets on data_out/ctrl_out; the emulator forwards them as gmii_rxd/gmii_rxc.
- Frame sequence: start token, preamble, SFD, incrementing payload, optional FCS, terminate token, then a programmable inter-packet gap.
- Byte rate is paced by fmac_speed: 1G, 100M or 10M.

## Interface
Parameters:
- MIN_IPG, 12, minimum idle bytes between packets; a smaller ipg_len is raised to this value.
- PREAMBLE_LEN, 6, number of 0x55 bytes between the start token and the SFD.

Ports:
- xaui_clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fmac_speed  in  2  byte pacing: 00/01 = every cycle, 10 = every 10 cycles, 11 = every 100 cycles.
- start  in  1  one-cycle request to begin a burst.
- pkt_len  in  11  payload bytes per packet; 0 is treated as 1.
- pkt_num  in  8  packets per burst; 0 is treated as 1.
- ipg_len  in  8  idle bytes after each terminate token.
- seed  in  8  value of the first payload byte of the burst.
- data_out  out  8  GMII byte.
- ctrl_out  out  1  1 = control byte (0xFB, 0xFD, 0x07); 0 = data byte.
- busy  out  1  burst in progress.
- pkt_done  out  1  one-cycle pulse on the cycle the 0xFD byte is first presented.
- pkt_cnt  out  8  packets completed in the current burst.

## Operation
- States: IDLE → SOP → PRE → SFD → PAY → (FCS) → EOP → IPG → SOP or IDLE.
- **IDLE**
  - Outputs 0x07 with ctrl=1.
  - start=1 latches pkt_len, pkt_num, ipg_len, seed and fmac_speed, clears pkt_cnt, sets busy and enters SOP.
- **SOP**: 0xFB, ctrl=1.
- **PRE**: PREAMBLE_LEN bytes of 0x55, ctrl=0.
- **SFD**: 0xD5, ctrl=0.
- **PAY**
  - pkt_len bytes, ctrl=0.
  - First byte = running value; each later byte = previous + 1, modulo 256.
  - The running value starts at seed and continues across packets of a burst; it does not reset per packet.
- **EOP**: 0xFD, ctrl=1; pkt_done pulses and pkt_cnt increments.
- **IPG**
  - Outputs max(ipg_len, MIN_IPG) bytes of 0x07, ctrl=1.
  - Then returns to SOP if pkt_cnt < pkt_num, else goes to IDLE and clears busy.
- **Pacing**
  - A byte-strobe counter is latched at start.
  - Each output byte is held for 1, 10 or 100 cycles; state advances only on the strobe.
  - The counter wraps 9→0 or 99→0 and restarts at 0 on start.
- start while busy is ignored; latched values are stable for the whole burst.
- fmac_speed changes during a burst are ignored.

## Timing
- Reset values:
  - data_out=0x07, ctrl_out=1, busy=0, pkt_done=0, pkt_cnt=0.
  - State IDLE, pacing counter 0.
- Reset asserted mid-frame forces the reset values immediately; no 0xFD is emitted.
- Outputs are registered. At 1G, with start sampled at cycle 0:
  - 0xFB at cycle 1.
  - Preamble at cycles 2–7.
  - 0xD5 at cycle 8.
  - Payload at cycles 9..8+L.
  - 0xFD at cycle 9+L (13+L with FCS).
- busy rises at cycle 1 and falls on the cycle after the last IPG byte.
- At 10M/100M, every cycle count above is multiplied by 100/10.
- pkt_done pulses for exactly one clock, including at slow speeds.
- pkt_cnt saturates at 255.

## Configuration
- **PKT_GEN_FCS_EN defined**
  - Adds state FCS between PAY and EOP.
  - Emits 4 bytes, ctrl=0: Ethernet CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement), least-significant byte first.
  - CRC covers payload bytes only; it is reinitialised at each SOP.
- **Not defined**: EOP directly follows the last payload byte; no CRC logic is synthesised.

## Test plan
- Reset, then speed 01, start with pkt_len=4, pkt_num=1, seed=0x10, ipg_len=12:
  - Sequence FB, 55×6, D5, 10, 11, 12, 13, FD, then 07×12.
  - ctrl pattern 1, 0×11, 1, 1×12; busy drops at cycle 26.
- pkt_num=3, pkt_len=2, seed=0xFE, ipg_len=3:
  - Payloads FE FF / 00 01 / 02 03.
  - Gaps of exactly 12 idles (MIN_IPG applied); pkt_cnt ends at 3; three pkt_done pulses.
- Speed 10, pkt_len=1:
  - Each byte held 10 cycles; 0xFB appears at cycles 1–10.
  - pkt_done is a single-cycle pulse at the first 0xFD cycle.
- Assert start again at cycle 5 of a burst:
  - Ignored; the burst completes unchanged.
- Assert reset during payload byte 3 of pkt_len=64:
  - Outputs return to 0x07/1 and busy=0 without waiting for a clock edge.
  - A following start produces a fresh frame beginning with 0xFB.
- With PKT_GEN_FCS_EN defined, pkt_len=4, payload 0x00,0x01,0x02,0x03:
  - FCS bytes equal the reference-model CRC-32 of that payload, LSB first, before 0xFD.
  - 0xFD appears at cycle 17.
